// File: rtl/key_bank.sv
// key_bank: synchronises and debounces N_KEYS raw key pins and turns each debounced key
// into level, press, release, long-press and auto-repeat events, all registered.
module key_bank #(
  parameter int N_KEYS       = 4,
  parameter int FILTER_LEN   = 4,
  parameter int ACTIVE_LOW   = 1,
  parameter int LONG_TICKS   = 100,
  parameter int REPEAT_TICKS = 20,
  parameter int CNT_W        = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              time_flag,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long,
  output logic [N_KEYS-1:0] key_repeat,
  output logic              key_any
);

  typedef enum logic [1:0] {
    ST_REL  = 2'd0,
    ST_HELD = 2'd1,
    ST_LONG = 2'd2
  } state_t;

  // The filter keeps raw pin polarity, so "pressed" is a raw low for active-low keys.
  localparam logic                  PRESS_RAW  = (ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
  localparam logic                  IDLE_RAW   = ~PRESS_RAW;
  localparam logic [N_KEYS-1:0]     SYNC_IDLE  = {N_KEYS{IDLE_RAW}};
  localparam logic [FILTER_LEN-1:0] WIN_PRESS  = {FILTER_LEN{PRESS_RAW}};
  localparam logic [FILTER_LEN-1:0] WIN_IDLE   = {FILTER_LEN{IDLE_RAW}};
  localparam logic [FILTER_LEN-2:0] HIST_IDLE  = {(FILTER_LEN-1){IDLE_RAW}};
  localparam logic [CNT_W-1:0]      LONG_CNT   = CNT_W'(LONG_TICKS);
  localparam logic [CNT_W-1:0]      REPEAT_CNT = CNT_W'(REPEAT_TICKS);

  logic [N_KEYS-1:0] r_sync1;
  logic [N_KEYS-1:0] r_sync2;
  logic [N_KEYS-1:0] w_levelNext;
  logic [N_KEYS-1:0] w_pressNext;
  logic [N_KEYS-1:0] w_releaseNext;
  logic [N_KEYS-1:0] w_longNext;
  logic [N_KEYS-1:0] w_repeatNext;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1     <= SYNC_IDLE;
      r_sync2     <= SYNC_IDLE;
      key_level   <= '0;
      key_press   <= '0;
      key_release <= '0;
      key_long    <= '0;
      key_repeat  <= '0;
      key_any     <= 1'b0;
    end else begin
      r_sync1     <= key_in;
      r_sync2     <= r_sync1;
      key_level   <= w_levelNext;
      key_press   <= w_pressNext;
      key_release <= w_releaseNext;
      key_long    <= w_longNext;
      key_repeat  <= w_repeatNext;
      key_any     <= |w_levelNext;
    end
  end

  for (genvar g = 0; g < N_KEYS; g++) begin : g_chan
    logic [FILTER_LEN-2:0] r_hist;
    logic [FILTER_LEN-1:0] w_window;
    state_t                r_state;
    state_t                w_stateNext;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cntNext;
    logic [CNT_W-1:0]      w_cntInc;
    logic                  w_level;
    logic                  w_press;
    logic                  w_release;
    logic                  w_long;
    logic                  w_repeat;

    // The oldest sample falls out on every shift, so only FILTER_LEN-1 history bits are stored.
    assign w_window = {r_hist, r_sync2[g]};
    assign w_cntInc = r_cnt + CNT_W'(1);

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        r_hist  <= HIST_IDLE;
        r_state <= ST_REL;
        r_cnt   <= '0;
      end else if (time_flag) begin
        r_hist  <= w_window[FILTER_LEN-2:0];
        r_state <= w_stateNext;
        r_cnt   <= w_cntNext;
      end
    end

    always_comb begin
      w_stateNext = r_state;
      w_cntNext   = r_cnt;
      w_level     = key_level[g];
      w_press     = 1'b0;
      w_release   = 1'b0;
      w_long      = 1'b0;
      w_repeat    = 1'b0;
      if (time_flag) begin
        unique case (r_state)
          ST_REL: begin
            if (w_window == WIN_PRESS) begin
              w_stateNext = ST_HELD;
              w_level     = 1'b1;
              w_press     = 1'b1;
              w_cntNext   = '0;
            end
          end
          ST_HELD: begin
            if (w_window == WIN_IDLE) begin
              w_stateNext = ST_REL;
              w_level     = 1'b0;
              w_release   = 1'b1;
            end else if (w_cntInc == LONG_CNT) begin
              w_stateNext = ST_LONG;
              w_long      = 1'b1;
              w_cntNext   = '0;
            end else begin
              w_cntNext = w_cntInc;
            end
          end
          ST_LONG: begin
            // Release is tested first so it wins over a repeat landing on the same tick.
            if (w_window == WIN_IDLE) begin
              w_stateNext = ST_REL;
              w_level     = 1'b0;
              w_release   = 1'b1;
            end else if (REPEAT_TICKS != 0) begin
              if (w_cntInc == REPEAT_CNT) begin
                w_repeat  = 1'b1;
                w_cntNext = '0;
              end else begin
                w_cntNext = w_cntInc;
              end
            end
          end
          default: begin
            w_stateNext = ST_REL;
            w_cntNext   = '0;
          end
        endcase
      end
    end

    assign w_levelNext[g]   = w_level;
    assign w_pressNext[g]   = w_press;
    assign w_releaseNext[g] = w_release;
    assign w_longNext[g]    = w_long;
    assign w_repeatNext[g]  = w_repeat;
  end

endmodule

// File: tb/tb_key_bank.sv
// tb_key_bank: directed stimulus for key_bank, checked every clock against a tick-level
// behavioural model, plus literal tick-distance and count checks for each scenario.
module tb_key_bank;

  localparam int NK = 4;
  localparam int FL = 4;
  localparam int LT = 8;
  localparam int RT = 3;

  logic          clock     = 1'b0;
  logic          reset     = 1'b0;
  logic          time_flag = 1'b0;
  logic [NK-1:0] key_in    = 4'hF;

  logic [NK-1:0] key_level, key_press, key_release, key_long, key_repeat;
  logic          key_any;
  logic [NK-1:0] key_level2, key_press2, key_release2, key_long2, key_repeat2;
  logic          key_any2;

  key_bank #(.N_KEYS(NK), .FILTER_LEN(FL), .ACTIVE_LOW(1), .LONG_TICKS(LT),
             .REPEAT_TICKS(RT), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .time_flag(time_flag), .key_in(key_in),
    .key_level(key_level), .key_press(key_press), .key_release(key_release),
    .key_long(key_long), .key_repeat(key_repeat), .key_any(key_any));

  key_bank #(.N_KEYS(NK), .FILTER_LEN(FL), .ACTIVE_LOW(1), .LONG_TICKS(LT),
             .REPEAT_TICKS(0), .CNT_W(8)) dutNoRep (
    .clock(clock), .reset(reset), .time_flag(time_flag), .key_in(key_in),
    .key_level(key_level2), .key_press(key_press2), .key_release(key_release2),
    .key_long(key_long2), .key_repeat(key_repeat2), .key_any(key_any2));

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int globalTick = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Tick generator: one-clock time_flag every 10 clocks.
  initial begin
    int div = 0;
    forever begin
      @(negedge clock);
      if (div == 9) begin
        time_flag = 1'b1;
        div = 0;
      end else begin
        time_flag = 1'b0;
        div++;
      end
    end
  end

  // Model: run lengths of agreeing tick samples and ticks elapsed since press.
  logic [NK-1:0] expLevel = '0, expPress = '0, expRel = '0, expLong = '0, expRep = '0;
  logic [NK-1:0] mh1 = 4'hF, mh2 = 4'hF;
  int  runP [NK];
  int  runR [NK];
  int  held [NK];
  int  sincePress [NK];

  initial begin
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
        expLevel = '0; expPress = '0; expRel = '0; expLong = '0; expRep = '0;
        mh1 = 4'hF; mh2 = 4'hF;
        for (int c = 0; c < NK; c++) begin
          runP[c] = 0; runR[c] = FL; held[c] = 0; sincePress[c] = 0;
        end
      end else begin
        expPress = '0; expRel = '0; expLong = '0; expRep = '0;
        if (time_flag) begin
          globalTick++;
          for (int c = 0; c < NK; c++) begin
            if (mh2[c] == 1'b0) begin
              runP[c] = (runP[c] < FL) ? runP[c] + 1 : FL;
              runR[c] = 0;
            end else begin
              runR[c] = (runR[c] < FL) ? runR[c] + 1 : FL;
              runP[c] = 0;
            end
            if (held[c] == 0) begin
              if (runP[c] == FL) begin
                held[c] = 1; sincePress[c] = 0; expPress[c] = 1'b1; expLevel[c] = 1'b1;
              end
            end else if (runR[c] == FL) begin
              held[c] = 0; expRel[c] = 1'b1; expLevel[c] = 1'b0;
            end else begin
              sincePress[c]++;
              if (sincePress[c] == LT) expLong[c] = 1'b1;
              else if (sincePress[c] > LT && ((sincePress[c] - LT) % RT) == 0) expRep[c] = 1'b1;
            end
          end
        end
        mh2 = mh1;
        mh1 = key_in;
      end
    end
  end

  // Event statistics, cleared on request through clearGen.
  int pressCnt [NK], relCnt [NK], longCnt [NK], repCnt [NK];
  int pressTick [NK], relTick [NK], longTick [NK], firstRep [NK], lastRep [NK];
  int long2Cnt = 0, rep2Cnt = 0, sawPress1001 = 0, sawRel0001 = 0;
  int clearGen = 0;

  // Compare process: DUT outputs against the model on every clock, then statistics.
  initial begin
    int seenGen = 0;
    forever begin
      @(negedge clock);
      checkOutput("level", key_level, expLevel);
      checkOutput("press", key_press, expPress);
      checkOutput("release", key_release, expRel);
      checkOutput("long", key_long, expLong);
      checkOutput("repeat", key_repeat, expRep);
      checkOutput("any", key_any, |expLevel);
      checkOutput("level_norep", key_level2, expLevel);
      checkOutput("press_norep", key_press2, expPress);
      checkOutput("release_norep", key_release2, expRel);
      checkOutput("long_norep", key_long2, expLong);
      checkOutput("repeat_norep", key_repeat2, 4'b0000);
      if (seenGen != clearGen) begin
        seenGen = clearGen;
        long2Cnt = 0; rep2Cnt = 0; sawPress1001 = 0; sawRel0001 = 0;
        for (int c = 0; c < NK; c++) begin
          pressCnt[c] = 0; relCnt[c] = 0; longCnt[c] = 0; repCnt[c] = 0;
          pressTick[c] = 0; relTick[c] = 0; longTick[c] = 0; firstRep[c] = 0; lastRep[c] = 0;
        end
      end
      if (key_press == 4'b1001) sawPress1001 = 1;
      if (key_release == 4'b0001) sawRel0001 = 1;
      if (key_long2[2]) long2Cnt++;
      if (key_repeat2[2]) rep2Cnt++;
      for (int c = 0; c < NK; c++) begin
        if (key_press[c]) begin pressCnt[c]++; pressTick[c] = globalTick; end
        if (key_release[c]) begin relCnt[c]++; relTick[c] = globalTick; end
        if (key_long[c]) begin longCnt[c]++; longTick[c] = globalTick; end
        if (key_repeat[c]) begin
          if (repCnt[c] == 0) firstRep[c] = globalTick;
          repCnt[c]++;
          lastRep[c] = globalTick;
        end
      end
    end
  end

  task automatic applyStimulus(input logic [NK-1:0] keys);
    key_in = keys;
  endtask

  task automatic clearStats();
    clearGen++;
    @(negedge clock);
    #1;
  endtask

  task automatic waitTicks(input int n);
    int target = globalTick + n;
    int budget = n * 10 + 40;
    while (globalTick < target && budget > 0) begin
      @(negedge clock);
      #1;
      budget--;
    end
    if (globalTick < target) begin
      checks++;
      errors++;
      $display("[TB] FAIL tickWait actual=%0d expected=%0d", globalTick, target);
    end
  endtask

  initial begin
    int chg;
    int pT;
    repeat (3) @(negedge clock);
    #1;
    checkOutput("reset_level", key_level, 4'b0000);
    checkOutput("reset_press", key_press, 4'b0000);
    checkOutput("reset_any", key_any, 1'b0);
    reset = 1'b1;
    waitTicks(2);

    // Single key press and release on channel 0.
    clearStats();
    chg = globalTick;
    applyStimulus(4'b1110);
    waitTicks(6);
    checkOutput("t1_pressCnt", pressCnt[0], 1);
    checkOutput("t1_pressLatency", pressTick[0] - chg, 4);
    checkOutput("t1_level", key_level, 4'b0001);
    checkOutput("t1_any", key_any, 1'b1);
    waitTicks(3);
    chg = globalTick;
    applyStimulus(4'b1111);
    waitTicks(6);
    checkOutput("t1_relCnt", relCnt[0], 1);
    checkOutput("t1_relLatency", relTick[0] - chg, 4);
    checkOutput("t1_levelAfter", key_level, 4'b0000);

    // Bouncing channel 1 never settles for four consecutive ticks.
    clearStats();
    for (int i = 0; i < 100; i++) begin
      if (i % 7 == 0) key_in[1] = ~key_in[1];
      @(negedge clock);
      #1;
    end
    key_in[1] = 1'b1;
    waitTicks(6);
    checkOutput("t2_press", pressCnt[0] + pressCnt[1] + pressCnt[2] + pressCnt[3], 0);
    checkOutput("t2_release", relCnt[0] + relCnt[1] + relCnt[2] + relCnt[3], 0);
    checkOutput("t2_level", key_level, 4'b0000);

    // Long press and auto-repeat on channel 2; release lands on a repeat tick.
    clearStats();
    chg = globalTick;
    applyStimulus(4'b1011);
    waitTicks(4);
    checkOutput("t3_pressLatency", pressTick[2] - chg, 4);
    pT = pressTick[2];
    waitTicks(25);
    applyStimulus(4'b1111);
    waitTicks(6);
    checkOutput("t3_longCnt", longCnt[2], 1);
    checkOutput("t3_longTick", longTick[2] - pT, 8);
    checkOutput("t3_firstRep", firstRep[2] - longTick[2], 3);
    checkOutput("t3_repCnt", repCnt[2], 6);
    checkOutput("t3_lastRep", lastRep[2] - pT, 26);
    checkOutput("t3_relTick", relTick[2] - pT, 29);

    // Two channels pressed together, one released.
    clearStats();
    applyStimulus(4'b0110);
    waitTicks(6);
    checkOutput("t4_press1001", sawPress1001, 1);
    checkOutput("t4_level", key_level, 4'b1001);
    applyStimulus(4'b0111);
    waitTicks(6);
    checkOutput("t4_rel0001", sawRel0001, 1);
    checkOutput("t4_level1000", key_level, 4'b1000);
    checkOutput("t4_relCnt3", relCnt[3], 0);
    applyStimulus(4'b1111);
    waitTicks(6);

    // Asynchronous reset while channel 1 is in long-press.
    clearStats();
    applyStimulus(4'b1101);
    waitTicks(14);
    checkOutput("t5_longBefore", longCnt[1], 1);
    @(negedge clock);
    #3;
    reset = 1'b0;
    #1;
    checkOutput("t5_asyncLevel", key_level, 4'b0000);
    checkOutput("t5_asyncAny", key_any, 1'b0);
    checkOutput("t5_asyncLevel2", key_level2, 4'b0000);
    begin
      int budget = 40;
      do begin
        @(negedge clock);
        #1;
        budget--;
      end while (!time_flag && budget > 0);
      checkOutput("t5_tickSeen", time_flag, 1'b1);
    end
    @(negedge clock);
    #1;
    chg = globalTick;
    reset = 1'b1;
    clearStats();
    waitTicks(6);
    checkOutput("t5_pressCnt", pressCnt[1], 1);
    checkOutput("t5_pressLatency", pressTick[1] - chg, 4);
    checkOutput("t5_relCnt", relCnt[1], 0);
    applyStimulus(4'b1111);
    waitTicks(6);

    // Thirty-tick hold: repeat-disabled instance gives one long and no repeats.
    clearStats();
    applyStimulus(4'b1011);
    waitTicks(34);
    applyStimulus(4'b1111);
    waitTicks(6);
    checkOutput("t6_long2Cnt", long2Cnt, 1);
    checkOutput("t6_rep2Cnt", rep2Cnt, 0);
    checkOutput("t6_repCnt", repCnt[2], 8);
    checkOutput("t6_relCnt", relCnt[2], 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
